dispatch_scheduler: RTL and testbench
=====================================

# dispatch_scheduler

Sits between the fetch queue and `instructionDecode`, and sequences decode-and-issue for the out-of-order core. It holds one fetched instruction and classifies it by opcode into a target reservation station. It issues the instruction only when the ROB has a free slot and that station is free, then allocates the ROB tag from a circular tail pointer. It replaces free-running decode pulses with a handshake-driven, back-pressured issue stage.

## Interface
Parameters:
- `ROB_DEPTH`, 8: ROB entries; power of two.
- `TAG_W`, 3: log2(ROB_DEPTH).

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch queue presents an instruction.
- `fetch_instr`  in  32  instruction word.
- `fetch_ready`  out  1  scheduler accepts `fetch_instr` this cycle.
- `alu_rs_free`  in  1  ALU reservation station has a free entry.
- `mem_rs_free`  in  1  load/store station has a free entry.
- `br_rs_free`  in  1  branch station has a free entry.
- `commit_valid`  in  1  ROB retires one entry this cycle.
- `flush`  in  1  mispredict/exception flush.
- `issue_valid`  out  1  instruction issued this cycle (drives decode and ROB allocation).
- `issue_unit`  out  2  target: 0 ALU, 1 MEM, 2 BR, 3 NONE (illegal opcode; ROB slot only).
- `issue_tag`  out  TAG_W  allocated ROB tag.
- `issue_instr`  out  32  held instruction word.
- `rob_count`  out  TAG_W+1  occupied ROB entries.
- `stall_cycles`  out  16  saturating count of cycles spent in HELD without issuing.

## Operation
- FSM has two states. EMPTY means no instruction is held. HELD means `hold_instr` is valid.
- Classification uses `hold_instr[6:0]`:
  - ALU: 0110111 (LUI), 0010111 (AUIPC), 0010011 (Op-imm), 0110011 (Op), 0001111 (FENCE).
  - MEM: 0000011 (load), 0100011 (store).
  - BR: 1101111 (JAL), 1100111 (JALR), 1100011 (branch).
  - Any other opcode maps to NONE.
- `can_issue` requires all of the following:
  - state is HELD;
  - `flush` is 0;
  - `rob_count < ROB_DEPTH`;
  - the target station's free flag is 1 (NONE needs no station);
  - for FENCE only, `rob_count == 0`.
- `issue_valid = can_issue`. This is combinational from registered state and inputs.
- `issue_instr = hold_instr` and `issue_tag = tail`. Both are valid whenever `issue_valid` = 1.
- `fetch_ready = !flush && (state == EMPTY || can_issue)`. This allows back-to-back acceptance in the same cycle as an issue.
- Accept means `fetch_valid && fetch_ready`. On accept, load `hold_instr`; state becomes or stays HELD.
- Issue without a same-cycle accept moves state to EMPTY.
- On issue, `tail <= tail + 1` modulo ROB_DEPTH, wrapping from ROB_DEPTH-1 to 0.
- `rob_count` next value is `rob_count + issue - (commit_valid && rob_count != 0)`:
  - simultaneous issue and commit leaves the count unchanged;
  - commit at count 0 is ignored.
- `stall_cycles` increments when state is HELD and `!can_issue` and `!flush`. It saturates at 0xFFFF and is cleared only by reset.
- `flush` overrides all other activity in its cycle:
  - state goes to EMPTY, `tail` to 0, `rob_count` to 0;
  - no issue and no accept occur;
  - `commit_valid` is ignored.

## Timing
- Reset (`rst_n` = 0, asynchronous) forces:
  - state EMPTY, `tail` = 0, `rob_count` = 0, `stall_cycles` = 0, `hold_instr` = 0;
  - outputs `issue_valid` = 0, `issue_unit` = 0, `issue_tag` = 0, `issue_instr` = 0, `fetch_ready` = 1.
- Reset assertion mid-operation drops the held instruction with no issue. Release is synchronous to the next `clock` edge.
- Latency: an instruction accepted at edge N is issue-eligible in cycle N+1. It issues in that cycle at the earliest.
- Throughput: one issue per cycle while resources are available.
- Full ROB (`rob_count == ROB_DEPTH`):
  - the scheduler holds the instruction and `fetch_ready` = 0;
  - a commit in a cycle only takes effect on the count at the next edge, so issue resumes the cycle after that commit.
- Station busy: hold and stall. Flags of the other stations are irrelevant.
- `issue_unit` must be decoded combinationally from `hold_instr`. It is valid whenever state is HELD; otherwise it is 0.

## Test plan
- Reset, then stream 3 instructions with all stations free:
  - 0x00500093 (addi) then 0x0000A103 (lw) then 0x00208463 (beq);
  - required: issue in consecutive cycles, unit 0/1/2, tags 0/1/2, `rob_count` = 3, `fetch_ready` held 1.
- Fill the ROB:
  - issue 8 ALU ops with no commit; the 9th is held with `fetch_ready` = 0 and `stall_cycles` incrementing;
  - assert `commit_valid` one cycle; the 9th issues the next cycle with tag 0 (wrap-around) and `rob_count` = 8.
- Hold the branch station busy:
  - present 0x0000006F (JAL) with `br_rs_free` = 0 for 5 cycles;
  - required: no issue, `stall_cycles` = 5; the JAL issues in the first cycle `br_rs_free` = 1.
- FENCE with `rob_count` = 2:
  - FENCE is held until two commits drain the ROB to 0, then issues on unit 0;
  - simultaneous issue+commit elsewhere keeps `rob_count` constant.
- Flush while HELD and `rob_count` = 5, with `commit_valid` = 1 in the same cycle:
  - next cycle: EMPTY, `rob_count` = 0, `tail` = 0, no issue in the flush cycle;
  - the next accepted instruction gets tag 0.
- Illegal opcode 0x0000007F issues with unit 3 and a tag. Assert `rst_n` low mid-HELD: all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dispatch_scheduler.sv
// rtl/dispatch_scheduler.sv - single-entry decode/issue stage with ROB tag allocation
module dispatch_scheduler #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = 3
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [31:0]       fetch_instr,
    output logic              fetch_ready,
    input  logic              alu_rs_free,
    input  logic              mem_rs_free,
    input  logic              br_rs_free,
    input  logic              commit_valid,
    input  logic              flush,
    output logic              issue_valid,
    output logic [1:0]        issue_unit,
    output logic [TAG_W-1:0]  issue_tag,
    output logic [31:0]       issue_instr,
    output logic [TAG_W:0]    rob_count,
    output logic [15:0]       stall_cycles
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    localparam logic [1:0] UNIT_ALU  = 2'd0;
    localparam logic [1:0] UNIT_MEM  = 2'd1;
    localparam logic [1:0] UNIT_BR   = 2'd2;
    localparam logic [1:0] UNIT_NONE = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [TAG_W:0]   ROB_FULL  = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0]   COUNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE   = TAG_W'(1);

    state_t             state;
    state_t             state_next;
    logic [31:0]        hold_instr;
    logic [TAG_W-1:0]   tail;
    logic [1:0]         unit_dec;
    logic               is_fence;
    logic               station_free;
    logic               can_issue;
    logic               accept;
    logic               commit_eff;

    // Opcode classification of the held word into its target station
    always_comb begin
        unit_dec = UNIT_NONE;
        is_fence = 1'b0;
        case (hold_instr[6:0])
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: unit_dec = UNIT_ALU;
            OP_FENCE: begin
                unit_dec = UNIT_ALU;
                is_fence = 1'b1;
            end
            OP_LOAD, OP_STORE:            unit_dec = UNIT_MEM;
            OP_JAL, OP_JALR, OP_BRANCH:   unit_dec = UNIT_BR;
            default:                      unit_dec = UNIT_NONE;
        endcase
    end

    // Only the targeted station's free flag matters; illegal opcodes need none
    always_comb begin
        station_free = 1'b1;
        case (unit_dec)
            UNIT_ALU: station_free = alu_rs_free;
            UNIT_MEM: station_free = mem_rs_free;
            UNIT_BR:  station_free = br_rs_free;
            default:  station_free = 1'b1;
        endcase
    end

    // Issue gate: FENCE additionally waits for an empty ROB
    always_comb begin
        can_issue = (state == HELD) && !flush && (rob_count < ROB_FULL) && station_free &&
                    (!is_fence || (rob_count == '0));
        fetch_ready = !flush && ((state == EMPTY) || can_issue);
        accept      = fetch_valid && fetch_ready;
        commit_eff  = commit_valid && (rob_count != '0) && !flush;
    end

    // Next-state: flush empties, accept holds, issue alone empties
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else if (accept) begin
            state_next = HELD;
        end else if (can_issue) begin
            state_next = EMPTY;
        end
    end

    // State register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Capture the fetched word on accept
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr <= '0;
        end else if (accept) begin
            hold_instr <= fetch_instr;
        end
    end

    // Circular ROB tail; power-of-two depth makes the wrap implicit
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tail <= '0;
        end else if (flush) begin
            tail <= '0;
        end else if (can_issue) begin
            tail <= tail + TAG_ONE;
        end
    end

    // ROB occupancy: issue adds, commit removes, both together cancel
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rob_count <= '0;
        end else if (flush) begin
            rob_count <= '0;
        end else if (can_issue && !commit_eff) begin
            rob_count <= rob_count + COUNT_ONE;
        end else if (!can_issue && commit_eff) begin
            rob_count <= rob_count - COUNT_ONE;
        end
    end

    // Saturating count of held-but-blocked cycles, cleared only by reset
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state == HELD) && !can_issue && !flush && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    // Issue outputs are direct views of held state
    always_comb begin
        issue_valid = can_issue;
        issue_unit  = (state == HELD) ? unit_dec : UNIT_ALU;
        issue_tag   = tail;
        issue_instr = hold_instr;
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb/tb_dispatch_scheduler.sv - scoreboard bench for dispatch_scheduler
module tb_dispatch_scheduler;

    logic        clock;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic        alu_rs_free;
    logic        mem_rs_free;
    logic        br_rs_free;
    logic        commit_valid;
    logic        flush;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [2:0]  issue_tag;
    logic [31:0] issue_instr;
    logic [3:0]  rob_count;
    logic [15:0] stall_cycles;

    dispatch_scheduler #(.ROB_DEPTH(8), .TAG_W(3)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_ready  (fetch_ready),
        .alu_rs_free  (alu_rs_free),
        .mem_rs_free  (mem_rs_free),
        .br_rs_free   (br_rs_free),
        .commit_valid (commit_valid),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_tag    (issue_tag),
        .issue_instr  (issue_instr),
        .rob_count    (rob_count),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         iv;
        logic [1:0] unit;
        bit         fr;
        int         rob;
        int         stall;
    } status_t;

    typedef struct {
        int          tag;
        logic [31:0] instr;
    } issue_t;

    status_t st_q[$];
    issue_t  iq[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    bit          m_held;
    logic [31:0] m_word;
    int          m_rob;
    int          m_tail;
    int          m_stall;

    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] JAL   = 32'h0000006F;
    localparam logic [31:0] FENCE = 32'h0FF0000F;
    localparam logic [31:0] ILL   = 32'h0000007F;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] classify(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op inside {7'h37, 7'h17, 7'h13, 7'h33, 7'h0F}) return 2'd0;
        if (op inside {7'h03, 7'h23}) return 2'd1;
        if (op inside {7'h6F, 7'h67, 7'h63}) return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_reset();
        m_held  = 0;
        m_word  = '0;
        m_rob   = 0;
        m_tail  = 0;
        m_stall = 0;
        st_q.delete();
        iq.delete();
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model
    task automatic step(input bit fv, input logic [31:0] fi, input bit a, input bit m,
                        input bit b, input bit cm, input bit fl);
        logic [1:0] u;
        bit         free;
        bit         iss;
        bit         fr;
        status_t    s;
        @(posedge clock);
        #2;
        fetch_valid  = fv;
        fetch_instr  = fi;
        alu_rs_free  = a;
        mem_rs_free  = m;
        br_rs_free   = b;
        commit_valid = cm;
        flush        = fl;
        u    = classify(m_word);
        free = (u == 2'd3) || (u == 2'd0 && a) || (u == 2'd1 && m) || (u == 2'd2 && b);
        iss  = m_held && !fl && (m_rob < 8) && free && (m_word[6:0] != 7'h0F || m_rob == 0);
        fr   = !fl && (!m_held || iss);
        s.iv    = iss;
        s.unit  = m_held ? u : 2'd0;
        s.fr    = fr;
        s.rob   = m_rob;
        s.stall = m_stall;
        st_q.push_back(s);
        if (iss) iq.push_back('{tag: m_tail, instr: m_word});
        if (fl) begin
            m_held = 0;
            m_rob  = 0;
            m_tail = 0;
        end else begin
            if (m_held && !iss && m_stall < 65535) m_stall++;
            if (iss) m_tail = (m_tail + 1) % 8;
            m_rob = m_rob + (iss ? 1 : 0) - ((cm && m_rob > 0) ? 1 : 0);
            if (fv && fr) begin
                m_held = 1;
                m_word = fi;
            end else if (iss) begin
                m_held = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 1, 1, 1, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tagname);
        check({tagname, ".issue_valid"}, 32'(issue_valid), 32'd0);
        check({tagname, ".issue_unit"}, 32'(issue_unit), 32'd0);
        check({tagname, ".issue_tag"}, 32'(issue_tag), 32'd0);
        check({tagname, ".issue_instr"}, issue_instr, 32'd0);
        check({tagname, ".fetch_ready"}, 32'(fetch_ready), 32'd1);
        check({tagname, ".rob_count"}, 32'(rob_count), 32'd0);
        check({tagname, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
    endtask

    // Monitor: compare every cycle's status and pop the scoreboard on each issue
    always @(negedge clock) begin
        if (mon_en && st_q.size() > 0) begin
            status_t s;
            issue_t  e;
            s = st_q.pop_front();
            check("issue_valid", 32'(issue_valid), 32'(s.iv));
            check("issue_unit", 32'(issue_unit), 32'(s.unit));
            check("fetch_ready", 32'(fetch_ready), 32'(s.fr));
            check("rob_count", 32'(rob_count), 32'(s.rob));
            check("stall_cycles", 32'(stall_cycles), 32'(s.stall));
            if (issue_valid) begin
                if (iq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got tag %0d instr 0x%0h expected none", issue_tag, issue_instr);
                end else begin
                    e = iq.pop_front();
                    check("issue_tag", 32'(issue_tag), 32'(e.tag));
                    check("issue_instr", issue_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h0F, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h7F, 7'h00};

        rst_n = 0; fetch_valid = 0; fetch_instr = 0; alu_rs_free = 1; mem_rs_free = 1;
        br_rs_free = 1; commit_valid = 0; flush = 0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #2;
        rst_n  = 1;
        mon_en = 1;

        // Three back-to-back instructions, one per station
        step(1, ADDI, 1, 1, 1, 0, 0);
        step(1, LW,   1, 1, 1, 0, 0);
        step(1, BEQ,  1, 1, 1, 0, 0);
        idle(2);

        // Fill the ROB from tag 0, then release one entry
        step(0, 32'h0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 9; i++) step(1, ADDI + 32'(i << 20), 1, 1, 1, 0, 0);
        idle(4);
        step(0, 32'h0, 1, 1, 1, 1, 0);
        idle(2);

        // Branch station busy for five cycles
        step(0, 32'h0, 1, 1, 1, 0, 1);
        step(1, JAL, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 1, 0, 0, 0);
        step(0, 32'h0, 1, 1, 1, 0, 0);

        // FENCE waits for an empty ROB; issue plus commit keeps the count
        step(0, 32'h0, 1, 1, 1, 0, 1);
        step(1, ADDI, 1, 1, 1, 0, 0);
        step(1, ADDI, 1, 1, 1, 0, 0);
        step(1, FENCE, 1, 1, 1, 0, 0);
        step(0, 32'h0, 1, 1, 1, 1, 0);
        step(0, 32'h0, 1, 1, 1, 1, 0);
        step(1, ADDI, 1, 1, 1, 0, 0);
        step(1, ADDI, 1, 1, 1, 1, 0);
        step(0, 32'h0, 1, 1, 1, 1, 0);
        idle(1);

        // Flush while held at five entries with a coincident commit
        step(0, 32'h0, 1, 1, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(1, ADDI, 1, 1, 1, 0, 0);
        step(0, 32'h0, 0, 1, 1, 1, 1);
        step(1, LW, 1, 1, 1, 0, 0);
        idle(2);

        // Illegal opcode issues with no station; then asynchronous reset while held
        step(1, ILL, 0, 0, 0, 0, 0);
        step(1, ADDI, 0, 1, 1, 0, 0);
        step(0, 32'h0, 0, 1, 1, 0, 0);
        @(posedge clock);
        #2;
        mon_en = 0;
        fetch_valid = 0; alu_rs_free = 1; mem_rs_free = 1; br_rs_free = 1;
        commit_valid = 0; flush = 0;
        rst_n = 0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clock);
        #2;
        rst_n  = 1;
        mon_en = 1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            r = $urandom();
            step(($urandom_range(0, 9) < 7), {r[31:7], ops[$urandom_range(0, 11)]},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 99) < 3));
        end
        idle(3);
        @(negedge clock);
        #1;
        check("scoreboard_drained", 32'(iq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
